// File: rtl/mouse_cursor_overlay.sv
// Crosshair mouse-cursor overlay for the 65 MHz VGA pixel stream.
// Latches the cursor position once per frame; a left-click flashes the cursor for a few frames.
module mouse_cursor_overlay #(
  parameter int          CURSOR_SIZE  = 15,
  parameter int          GAP          = 2,
  parameter logic [11:0] CURSOR_COLOR = 12'hFFF,
  parameter logic [11:0] FIRE_COLOR   = 12'hF00,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] posX,
  input  logic [11:0] posY,
  input  logic        btn_left,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int          R          = (CURSOR_SIZE - 1) / 2;
  localparam logic [12:0] R13        = 13'(R);
  localparam logic [12:0] GAP13      = 13'(GAP);
  localparam logic [7:0]  FLASH_INIT = 8'(FLASH_FRAMES);

  function automatic logic [12:0] abs13(input logic signed [12:0] v);
    return v[12] ? 13'(-v) : 13'(v);
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  logic        vsync_q, btn_q;
  logic [11:0] cx, cy;
  logic [7:0]  flash_cnt;
  logic        vs_rise, btn_rise;

  assign vs_rise  = vsync_in & ~vsync_q;
  assign btn_rise = btn_left & ~btn_q;

  // A press reloads the flash even when a vsync edge lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      btn_q     <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      flash_cnt <= '0;
    end else begin
      vsync_q <= vsync_in;
      btn_q   <= btn_left;
      if (vs_rise) begin
        cx <= posX;
        cy <= posY;
      end
      if (btn_rise)
        flash_cnt <= FLASH_INIT;
      else if (vs_rise)
        flash_cnt <= sat_dec(flash_cnt);
    end
  end

  logic signed [12:0] dx, dy;
  logic        [12:0] adx, ady;
  logic               hit;

  assign dx  = $signed({2'b00, hcount_in}) - $signed({1'b0, cx});
  assign dy  = $signed({2'b00, vcount_in}) - $signed({1'b0, cy});
  assign adx = abs13(dx);
  assign ady = abs13(dy);

  // Positions at or beyond 2048 are off any 11-bit raster and must never draw.
  assign hit = ~cx[11] & ~cy[11]
             & (adx <= R13) & (ady <= R13)
             & ((dx == 13'sd0) | (dy == 13'sd0))
             & ~((adx <= GAP13) & (ady <= GAP13));

  logic        hit_p1, vld_p1;
  logic [11:0] color_p1, rgb_p1;
  logic [10:0] hcount_p1, vcount_p1;
  logic        hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;

  logic [11:0] rgb_p2;
  logic [10:0] hcount_p2, vcount_p2;
  logic        hsync_p2, vsync_p2, hblnk_p2, vblnk_p2;

  // Stage 1: hit test and colour select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      color_p1  <= '0;
      rgb_p1    <= '0;
      hcount_p1 <= '0;
      vcount_p1 <= '0;
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      hblnk_p1  <= 1'b0;
      vblnk_p1  <= 1'b0;
    end else begin
      hit_p1    <= hit;
      vld_p1    <= ~(hblnk_in | vblnk_in);
      color_p1  <= (flash_cnt != 8'd0) ? FIRE_COLOR : CURSOR_COLOR;
      rgb_p1    <= rgb_in;
      hcount_p1 <= hcount_in;
      vcount_p1 <= vcount_in;
      hsync_p1  <= hsync_in;
      vsync_p1  <= vsync_in;
      hblnk_p1  <= hblnk_in;
      vblnk_p1  <= vblnk_in;
    end
  end

  // Stage 2: composite cursor over background
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2    <= '0;
      hcount_p2 <= '0;
      vcount_p2 <= '0;
      hsync_p2  <= 1'b0;
      vsync_p2  <= 1'b0;
      hblnk_p2  <= 1'b0;
      vblnk_p2  <= 1'b0;
    end else begin
      rgb_p2    <= (vld_p1 & hit_p1) ? color_p1 : rgb_p1;
      hcount_p2 <= hcount_p1;
      vcount_p2 <= vcount_p1;
      hsync_p2  <= hsync_p1;
      vsync_p2  <= vsync_p1;
      hblnk_p2  <= hblnk_p1;
      vblnk_p2  <= vblnk_p1;
    end
  end

  assign rgb_out    = rgb_p2;
  assign hcount_out = hcount_p2;
  assign vcount_out = vcount_p2;
  assign hsync_out  = hsync_p2;
  assign vsync_out  = vsync_p2;
  assign hblnk_out  = hblnk_p2;
  assign vblnk_out  = vblnk_p2;

endmodule
